univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the successor to the 4-bit bidirectional load/shift register. It adds configurable width, logical, arithmetic and rotate modes, and serial in/out. A multi-position shift runs under a start/busy/done handshake at one position per clock. It serves as the generic shifter for serial links and datapath scratch registers.

## Interface
- WIDTH, default 8: register width, ≥ 2.
- CNT_W, default $clog2(WIDTH)+1: width of the shift amount, so counts 0..2^CNT_W-1 are expressible.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  parallel load of parallel_in.
- parallel_in  in  WIDTH  load data.
- start  in  1  begin a shift operation; sampled only when busy=0.
- mode  in  3  operation code: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 reserved.
- amount  in  CNT_W  number of single-position steps.
- sin_lsb  in  1  fill bit for SLL, sampled at every step.
- sin_msb  in  1  fill bit for SRL, sampled at every step.
- data_out  out  WIDTH  register contents.
- ser_out  out  1  bit shifted or rotated out on the most recent step.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse: the operation has completed.

## Operation
- FSM has two states, IDLE and SHIFT. Internal state: mode_q, remaining count cnt_q.
- Priority at each edge: rst > load > start/step.
- load=1: data_out ← parallel_in. If the FSM is in SHIFT, the operation is aborted: go to IDLE, busy=0, no done. ser_out is unchanged.
- IDLE, start=1 with a valid mode:
  - Latch mode and amount.
  - amount≠0: go to SHIFT with cnt_q=amount.
  - amount=0: stay in IDLE and pulse done; data_out is unchanged.
- IDLE, start=1 with a reserved mode: ignored. No busy, no done.
- SHIFT: each edge performs one step on data_out and decrements cnt_q. When cnt_q reaches 0, return to IDLE and pulse done.
- Step rules:
  - SLL: {d[W-2:0], sin_lsb}; ser_out ← d[W-1].
  - SRL: {sin_msb, d[W-1:1]}; ser_out ← d[0].
  - SRA: {d[W-1], d[W-1:1]}; ser_out ← d[0].
  - ROL: {d[W-2:0], d[W-1]}; ser_out ← d[W-1].
  - ROR: {d[0], d[W-1:1]}; ser_out ← d[0].
- Mode and amount inputs are ignored while busy. start while busy is dropped, not queued.
- amount ≥ WIDTH is legal: every step executes literally. Rotates wrap; logical shifts fill entirely with the sampled serial bits.

## Timing
- Reset values: data_out=0, ser_out=0, busy=0, done=0; FSM in IDLE, cnt_q=0.
- start accepted at edge k, amount=N>0:
  - Steps occur at edges k+1 .. k+N.
  - busy is high from after edge k until after edge k+N (N cycles).
  - done is high for the single cycle after edge k+N, together with busy low.
- start accepted at edge k, amount=0: done is high for the cycle after edge k; busy stays 0.
- Back-to-back operation: start may be asserted in the cycle where done=1, and it is accepted at that edge.
- load and start at the same edge: the load wins, and start is ignored.
- rst asserted mid-operation: all outputs clear immediately (asynchronously); no done is produced.
- Single-step shifts (amount=1) give one result per two cycles.

## Structure
- Shared package shift_pkg holds:
  - typedef enum shift_mode_e {SLL, SRL, SRA, ROL, ROR}, 3 bits;
  - the FSM state enum;
  - a localparam for the reserved-mode check.
- One combinational sub-module, shift_step (parameter WIDTH; inputs d, mode, sin_lsb, sin_msb; outputs d_next, bit_out), computes a single step. The top contains the FSM, the counter and the registers.

## Test plan
- WIDTH=4: load 1011, then start SLL amount 2 with sin_lsb=0 → busy for 2 cycles, data_out 0110 then 1100, ser_out=0, one done pulse.
- Load 1011, then SRA amount 1 → 1101, ser_out=1. Load 1011, then SRL amount 2 with sin_msb=1 → 1110, ser_out=1.
- Load 1011, then ROR amount 4 → 1011 after 4 busy cycles. Then ROL amount 1 → 0111, ser_out=1.
- amount=0 → done next cycle, busy never high, data unchanged. Reserved mode 6 → no busy, no done, data unchanged.
- Start SLL amount 3, then assert load 0101 after step 1 → data_out=0101, busy=0, no done. A start pulse while busy is ignored.
- Assert rst during step 2 of ROL amount 3 → all outputs 0 immediately. A fresh operation after reset completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and the helper that separates implemented modes from reserved ones.
package shift_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    // Highest implemented operation code; codes above it are reserved.
    localparam logic [2:0] MODE_MAX = 3'd4;

    function automatic logic mode_is_valid(input logic [2:0] m);
        return (m <= MODE_MAX);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One single-position step of the shifter: next register value and the bit
// that leaves the register on this step. Purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  shift_mode_e      mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] d_next,
    output logic             bit_out
);

    // Select the step result for the latched operation code.
    always_comb begin
        d_next  = d;
        bit_out = 1'b0;
        case (mode)
            SLL: begin
                d_next  = {d[WIDTH-2:0], sin_lsb};
                bit_out = d[WIDTH-1];
            end
            SRL: begin
                d_next  = {sin_msb, d[WIDTH-1:1]};
                bit_out = d[0];
            end
            SRA: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                bit_out = d[WIDTH-1];
            end
            ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            default: begin
                d_next  = d;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-position shift/rotate
// executed one position per clock under a start/busy/done handshake.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    shift_state_e     state_q;
    shift_mode_e      mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d       (data_q),
        .mode    (mode_q),
        .sin_lsb (sin_lsb),
        .sin_msb (sin_msb),
        .d_next  (step_data),
        .bit_out (step_bit)
    );

    // Control FSM, step counter and data registers; load overrides any shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= SLL;
            cnt_q   <= CNT_ZERO;
            data_q  <= {WIDTH{1'b0}};
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                // Load aborts any running operation silently: no done pulse.
                data_q  <= parallel_in;
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= CNT_ZERO;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && mode_is_valid(mode)) begin
                            mode_q <= shift_mode_e'(mode);
                            if (amount != CNT_ZERO) begin
                                state_q <= SHIFT;
                                cnt_q   <= amount;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    SHIFT: begin
                        data_q <= step_data;
                        ser_q  <= step_bit;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4): each started operation pushes
// its expected final data, serial bit and busy length; a monitor pops and
// compares on every done pulse. Abort and reset cases are checked directly.
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ser;
        int               busy_cycles;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    exp_t exp_q[$];
    int   total      = 0;
    int   passed     = 0;
    int   done_count = 0;
    int   busy_run   = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in),
        .start(start), .mode(mode), .amount(amount),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: pop one expectation per done pulse and count busy cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done with empty scoreboard");
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(data_out), 32'(e.data));
                check("sb_ser", 32'(ser_out), 32'(e.ser));
                check("sb_busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
                check("sb_done_not_busy", 32'(busy), 32'd0);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic do_load(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        load = 1'b1; parallel_in = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Issue a start, push its expectation, and wait (bounded) for idle.
    task automatic run_op(input logic [2:0] m, input logic [CNT_W-1:0] amt,
                          input logic sl, input logic sm,
                          input logic [WIDTH-1:0] ed, input logic es,
                          input int eb, input bit expect_done);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        start = 1'b1; mode = m; amount = amt; sin_lsb = sl; sin_msb = sm;
        if (expect_done) begin
            e.data = ed; e.ser = es; e.busy_cycles = eb;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy && !done) break;
            n++;
            if (n > 40) begin
                total++;
                $display("FAIL op_timeout: busy/done still active after %0d cycles", n);
                break;
            end
        end
    endtask

    initial begin
        int dc;
        exp_t e;
        rst = 1'b1; load = 1'b0; parallel_in = '0; start = 1'b0;
        mode = 3'd0; amount = '0; sin_lsb = 1'b0; sin_msb = 1'b0;
        #12;
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_ser", 32'(ser_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // SLL 2, fill 0: 1011 -> 0110 -> 1100, last bit out 0
        do_load(4'b1011);
        run_op(3'd0, 3'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 2, 1'b1);
        // SRA 1: 1011 -> 1101, out 1
        do_load(4'b1011);
        run_op(3'd2, 3'd1, 1'b0, 1'b0, 4'b1101, 1'b1, 1, 1'b1);
        // SRL 2, fill 1: 1011 -> 1101 -> 1110, out 1
        do_load(4'b1011);
        run_op(3'd1, 3'd2, 1'b0, 1'b1, 4'b1110, 1'b1, 2, 1'b1);
        // ROR 4 returns to 1011, last out bit 1
        do_load(4'b1011);
        run_op(3'd4, 3'd4, 1'b0, 1'b0, 4'b1011, 1'b1, 4, 1'b1);
        // ROL 1: 1011 -> 0111, out 1
        run_op(3'd3, 3'd1, 1'b0, 1'b0, 4'b0111, 1'b1, 1, 1'b1);
        // amount 0: immediate done, data and ser unchanged
        run_op(3'd0, 3'd0, 1'b1, 1'b1, 4'b0111, 1'b1, 0, 1'b1);

        // Reserved mode 6: nothing happens
        dc = done_count;
        run_op(3'd6, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("reserved_no_done", 32'(done_count), 32'(dc));
        check("reserved_data", 32'(data_out), 32'b0111);

        // amount 5 > WIDTH, SLL fill 1: 0111 -> 1111 (out 0), then all ones out 1
        run_op(3'd0, 3'd5, 1'b1, 1'b0, 4'b1111, 1'b1, 5, 1'b1);

        // Abort: SLL 3 on 1111, load 0101 after step 1 (step 1 ejects a 1)
        dc = done_count;
        @(posedge clk); #1;
        start = 1'b1; mode = 3'd0; amount = 3'd3; sin_lsb = 1'b0;
        e.data = 4'b0000; e.ser = 1'b0; e.busy_cycles = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_mid_data", 32'(data_out), 32'b1110);
        load = 1'b1; parallel_in = 4'b0101;
        @(posedge clk); #1;
        load = 1'b0;
        exp_q.delete();
        check("abort_data", 32'(data_out), 32'b0101);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ser", 32'(ser_out), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc));

        // Start while busy is dropped: ROL 3 on 0101 -> 1010, ser 0
        @(posedge clk); #1;
        start = 1'b1; mode = 3'd3; amount = 3'd3;
        e.data = 4'b1010; e.ser = 1'b0; e.busy_cycles = 3;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mode = 3'd0; amount = 3'd1;         // start still high while busy
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset during step 2 of ROL 3 on 1010
        dc = done_count;
        @(posedge clk); #1;
        start = 1'b1; mode = 3'd3; amount = 3'd3;
        e.data = 4'b0000; e.ser = 1'b0; e.busy_cycles = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_ser", 32'(ser_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_no_done", 32'(done_count), 32'(dc));

        // Fresh operation after reset: SRL 1 fill 0 on 0011 -> 0001, out 1
        do_load(4'b0011);
        run_op(3'd1, 3'd1, 1'b0, 1'b0, 4'b0001, 1'b1, 1, 1'b1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
